// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with zero-latency IF lookup, EX-stage update and
// misprediction recovery. Define BTB_BHT_EN to add a 2-bit saturating counter per entry.
module branch_target_buffer #(
  parameter int unsigned ENTRY_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        BRPredictedF,
  output logic [31:0] PredTargetF,
  input  logic        en,
  input  logic        BranchE,
  input  logic        BrTakenE,
  input  logic [31:0] PCE,
  input  logic [31:0] BrTargetE,
  input  logic        BRPredictedE,
  output logic        MispredictE,
  output logic [31:0] RecoverPCE,
  output logic [31:0] BrCount,
  output logic [31:0] MissCount
);

  localparam int unsigned N  = 1 << ENTRY_BITS;
  localparam int unsigned TW = 30 - ENTRY_BITS;

  logic [N-1:0]    valid_q;
  logic [TW-1:0]   tag_q [N];
  logic [31:0]     tgt_q [N];

  logic [ENTRY_BITS-1:0] idx_f, idx_e;
  logic [TW-1:0]         tag_f, tag_e;
  logic                  hit_f, hit_e, pred_f;
  logic                  br_ev, alloc, inval;
  logic                  unused_pc_lsbs;

  assign idx_f = PCF[ENTRY_BITS+1:2];
  assign tag_f = PCF[31:ENTRY_BITS+2];
  assign idx_e = PCE[ENTRY_BITS+1:2];
  assign tag_e = PCE[31:ENTRY_BITS+2];
  assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  assign br_ev = en & BranchE;
  assign alloc = br_ev & BrTakenE & ~hit_e;

`ifdef BTB_BHT_EN
  logic [1:0] ctr_q [N];
  assign pred_f = hit_f & ctr_q[idx_f][1];
  // Entries only leave the table when a non-branch was predicted taken.
  assign inval  = en & BRPredictedE & ~BranchE;
`else
  assign pred_f = hit_f;
  assign inval  = (en & BRPredictedE & ~BranchE) | (br_ev & ~BrTakenE & hit_e);
`endif

  assign BRPredictedF = pred_f;
  assign PredTargetF  = pred_f ? tgt_q[idx_f] : '0;

  assign MispredictE = en & ((BranchE & (BRPredictedE != BrTakenE)) | (~BranchE & BRPredictedE));
  assign RecoverPCE  = (BranchE & BrTakenE) ? BrTargetE : PCE + 32'd4;

  // Valid bits and counters carry the reset, so a write racing reset leaves no live entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      BrCount   <= '0;
      MissCount <= '0;
`ifdef BTB_BHT_EN
      for (int unsigned i = 0; i < N; i++) ctr_q[i] <= '0;
`endif
    end else begin
      if (alloc) valid_q[idx_e] <= 1'b1;
      if (inval) valid_q[idx_e] <= 1'b0;
      if (br_ev) BrCount <= BrCount + 32'd1;
      if (MispredictE) MissCount <= MissCount + 32'd1;
`ifdef BTB_BHT_EN
      if (alloc) begin
        ctr_q[idx_e] <= 2'b10;
      end else if (br_ev && hit_e) begin
        if (BrTakenE && ctr_q[idx_e] != 2'b11) ctr_q[idx_e] <= ctr_q[idx_e] + 2'd1;
        else if (!BrTakenE && ctr_q[idx_e] != 2'b00) ctr_q[idx_e] <= ctr_q[idx_e] - 2'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_q[idx_e] <= tag_e;
      tgt_q[idx_e] <= BrTargetE;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios plus randomized traffic
// against a table-of-branch-PCs reference model (honours BTB_BHT_EN).
module tb_branch_target_buffer;

  localparam int unsigned E = 4;
  localparam int unsigned N = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCF;
  logic        BRPredictedF;
  logic [31:0] PredTargetF;
  logic        en, BranchE, BrTakenE, BRPredictedE;
  logic [31:0] PCE, BrTargetE;
  logic        MispredictE;
  logic [31:0] RecoverPCE, BrCount, MissCount;

  int total = 0;
  int bad   = 0;

  branch_target_buffer #(.ENTRY_BITS(E)) dut (
    .clk(clk), .rst_n(rst_n), .PCF(PCF), .BRPredictedF(BRPredictedF),
    .PredTargetF(PredTargetF), .en(en), .BranchE(BranchE), .BrTakenE(BrTakenE),
    .PCE(PCE), .BrTargetE(BrTargetE), .BRPredictedE(BRPredictedE),
    .MispredictE(MispredictE), .RecoverPCE(RecoverPCE), .BrCount(BrCount),
    .MissCount(MissCount)
  );

  always #5 clk = ~clk;

  // Reference model: each slot remembers the full PC of the branch that owns it.
  bit          m_valid [N];
  logic [31:0] m_pc    [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  logic [31:0] m_br, m_miss;

  function automatic int unsigned ix(logic [31:0] pc);
    return (pc >> 2) % N;
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    int unsigned i = ix(pc);
    return m_valid[i] && ((m_pc[i] >> (E + 2)) == (pc >> (E + 2)));
  endfunction

  function automatic bit m_pred(logic [31:0] pc);
`ifdef BTB_BHT_EN
    return m_hit(pc) && (m_ctr[ix(pc)] >= 2);
`else
    return m_hit(pc);
`endif
  endfunction

  function automatic logic [31:0] m_target(logic [31:0] pc);
    return m_pred(pc) ? m_tgt[ix(pc)] : 32'd0;
  endfunction

  function automatic bit m_misp();
    if (!en) return 1'b0;
    return BranchE ? (BRPredictedE != BrTakenE) : BRPredictedE;
  endfunction

  function automatic logic [31:0] m_rec();
    return (BranchE && BrTakenE) ? BrTargetE : PCE + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 0;
    end
    m_br   = 32'd0;
    m_miss = 32'd0;
  endtask

  task automatic model_update();
    int unsigned i = ix(PCE);
    bit h  = m_hit(PCE);
    bit mp = m_misp();
    if (!rst_n || !en) return;
    if (BranchE) begin
      m_br = m_br + 32'd1;
      if (BrTakenE && !h) begin
        m_valid[i] = 1'b1;
        m_pc[i]    = PCE;
        m_tgt[i]   = BrTargetE;
        m_ctr[i]   = 2;
      end
`ifdef BTB_BHT_EN
      else if (h) m_ctr[i] = BrTakenE ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                      : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
`else
      else if (h && !BrTakenE) m_valid[i] = 1'b0;
`endif
    end else if (BRPredictedE) begin
      m_valid[i] = 1'b0;
    end
    if (mp) m_miss = m_miss + 32'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    en = 1'b0; BranchE = 1'b0; BrTakenE = 1'b0; BRPredictedE = 1'b0;
    PCE = 32'd0; BrTargetE = 32'd0;
  endtask

  task automatic set_ex(input logic e, input logic b, input logic t, input logic p,
                        input logic [31:0] pc, input logic [31:0] tgt);
    en = e; BranchE = b; BrTakenE = t; BRPredictedE = p; PCE = pc; BrTargetE = tgt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); PCF = 32'h100; model_reset();
    #3;
    total++; if (BRPredictedF !== 1'b0) begin bad++; $display("FAIL reset_pred got=%0b exp=0", BRPredictedF); end
    total++; if (PredTargetF !== 32'd0) begin bad++; $display("FAIL reset_tgt got=%h exp=0", PredTargetF); end
    total++; if (BrCount !== 32'd0 || MissCount !== 32'd0) begin bad++;
      $display("FAIL reset_counts br=%h miss=%h exp=0", BrCount, MissCount); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cold_branch();
    set_ex(1, 1, 1, 0, 32'h100, 32'h80); PCF = 32'h100;
    #1;
    total++; if (MispredictE !== 1'b1) begin bad++; $display("FAIL cold_misp got=%0b exp=1", MispredictE); end
    total++; if (RecoverPCE !== 32'h80) begin bad++; $display("FAIL cold_rec got=%h exp=00000080", RecoverPCE); end
    total++; if (BRPredictedF !== 1'b0) begin bad++; $display("FAIL same_idx_old got=%0b exp=0", BRPredictedF); end
    tick(); idle(); #1;
    total++; if (BRPredictedF !== 1'b1 || PredTargetF !== 32'h80) begin bad++;
      $display("FAIL cold_lookup got=%0b/%h exp=1/00000080", BRPredictedF, PredTargetF); end
    total++; if (BrCount !== 32'd1 || MissCount !== 32'd1) begin bad++;
      $display("FAIL cold_counts br=%0d miss=%0d exp=1/1", BrCount, MissCount); end
  endtask

  task automatic test_not_taken();
    set_ex(1, 1, 0, 1, 32'h100, 32'h80); PCF = 32'h100;
    #1;
    total++; if (MispredictE !== 1'b1 || RecoverPCE !== 32'h104) begin bad++;
      $display("FAIL nt_misp got=%0b/%h exp=1/00000104", MispredictE, RecoverPCE); end
    total++; if (BRPredictedF !== 1'b1) begin bad++; $display("FAIL nt_old_lookup got=%0b exp=1", BRPredictedF); end
    tick(); idle(); #1;
    total++; if (BRPredictedF !== 1'b0 || PredTargetF !== 32'd0) begin bad++;
      $display("FAIL nt_lookup got=%0b/%h exp=0/0", BRPredictedF, PredTargetF); end
  endtask

  task automatic test_alias();
    set_ex(1, 1, 1, 0, 32'h100, 32'h200); tick();
    set_ex(1, 1, 1, 0, 32'h140, 32'h300); tick();
    idle(); PCF = 32'h100; #1;
    total++; if (BRPredictedF !== 1'b0) begin bad++; $display("FAIL alias_old got=%0b exp=0", BRPredictedF); end
    PCF = 32'h140; #1;
    total++; if (BRPredictedF !== 1'b1 || PredTargetF !== 32'h300) begin bad++;
      $display("FAIL alias_new got=%0b/%h exp=1/00000300", BRPredictedF, PredTargetF); end
  endtask

  task automatic test_en_low();
    logic [31:0] br0, miss0;
    br0 = BrCount; miss0 = MissCount;
    set_ex(0, 1, 1, 0, 32'h180, 32'h999C); PCF = 32'h180;
    #1;
    total++; if (MispredictE !== 1'b0) begin bad++; $display("FAIL enlow_misp got=%0b exp=0", MispredictE); end
    tick(); idle(); #1;
    total++; if (BRPredictedF !== 1'b0) begin bad++; $display("FAIL enlow_noalloc got=%0b exp=0", BRPredictedF); end
    PCF = 32'h140; #1;
    total++; if (BRPredictedF !== 1'b1) begin bad++; $display("FAIL enlow_kept got=%0b exp=1", BRPredictedF); end
    total++; if (BrCount !== br0 || MissCount !== miss0) begin bad++;
      $display("FAIL enlow_counts br=%0d miss=%0d exp=%0d/%0d", BrCount, MissCount, br0, miss0); end
  endtask

  task automatic test_wrap();
    set_ex(1, 0, 0, 1, 32'hFFFF_FFFC, 32'h0); #1;
    total++; if (MispredictE !== 1'b1 || RecoverPCE !== 32'd0) begin bad++;
      $display("FAIL pc_wrap got=%0b/%h exp=1/00000000", MispredictE, RecoverPCE); end
    tick(); idle();
  endtask

  function automatic logic [31:0] rpc();
    return ((32'($urandom) % 4) << 6) | ((32'($urandom) % 16) << 2);
  endfunction

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      PCF = rpc();
      PCE = rpc();
      en = ($urandom % 5) != 0;
      BranchE = ($urandom % 4) != 0;
      BrTakenE = $urandom % 2;
      BRPredictedE = ($urandom % 2) ? m_pred(PCE) : 1'($urandom % 2);
      BrTargetE = {$urandom} & 32'hFFFF_FFFC;
      #1;
      total++; if (BRPredictedF !== m_pred(PCF) || PredTargetF !== m_target(PCF)) begin bad++;
        $display("FAIL rand_lookup pc=%h got=%0b/%h exp=%0b/%h", PCF, BRPredictedF, PredTargetF,
                 m_pred(PCF), m_target(PCF)); end
      total++; if (MispredictE !== m_misp() || (MispredictE && RecoverPCE !== m_rec())) begin bad++;
        $display("FAIL rand_misp got=%0b/%h exp=%0b/%h", MispredictE, RecoverPCE, m_misp(), m_rec()); end
      total++; if (BrCount !== m_br || MissCount !== m_miss) begin bad++;
        $display("FAIL rand_counts br=%0d miss=%0d exp=%0d/%0d", BrCount, MissCount, m_br, m_miss); end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0; model_reset(); #1; rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_ex(1, 1, 0, 0, 32'h400 + 32'(k) * 4, 32'h0);
      tick();
    end
    idle(); #1;
    total++; if (BrCount !== 32'd5) begin bad++; $display("FAIL pre_reset_br got=%0d exp=5", BrCount); end
    set_ex(1, 1, 1, 0, 32'h500, 32'h600); PCF = 32'h140;
    #2;
    rst_n = 1'b0; model_reset(); #1;
    total++; if (BrCount !== 32'd0 || MissCount !== 32'd0) begin bad++;
      $display("FAIL mid_reset_counts br=%0d miss=%0d exp=0/0", BrCount, MissCount); end
    total++; if (BRPredictedF !== 1'b0 || PredTargetF !== 32'd0) begin bad++;
      $display("FAIL mid_reset_lookup got=%0b/%h exp=0/0", BRPredictedF, PredTargetF); end
    tick();
    @(negedge clk); rst_n = 1'b1; idle(); PCF = 32'h500; #1;
    total++; if (BRPredictedF !== 1'b0) begin bad++; $display("FAIL reset_wins got=%0b exp=0", BRPredictedF); end
    tick();
  endtask

  initial begin
    test_reset();
    test_cold_branch();
    test_not_taken();
    test_alias();
    test_en_low();
    test_wrap();
    test_random();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 The block SHALL have parameter ENTRY_BITS, default 4, giving log2 of the entry count (16 entries).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port PCF, input, 32, the fetch-stage PC used for lookup.
REQ-005 The block SHALL have port BRPredictedF, output, 1, the taken prediction for PCF, carried down the pipe as BRPredictedD/E.
REQ-006 The block SHALL have port PredTargetF, output, 32, the predicted target; 0 when BRPredictedF=0.
REQ-007 The block SHALL have port en, input, 1, the EX-stage advance enable; no update or count occurs when it is 0.
REQ-008 The block SHALL have port BranchE, input, 1, indicating that the EX instruction is a conditional branch.
REQ-009 The block SHALL have port BrTakenE, input, 1, the resolved branch outcome.
REQ-010 The block SHALL have ports PCE and BrTargetE, input, 32 each, giving the EX PC and the resolved taken target.
REQ-011 The block SHALL have port BRPredictedE, input, 1, the prediction made in IF for the instruction now in EX.
REQ-012 The block SHALL have port MispredictE, output, 1, a combinational flush request for IF/ID/EX.
REQ-013 The block SHALL have port RecoverPCE, output, 32, the redirect PC, valid when MispredictE=1.
REQ-014 The block SHALL have ports BrCount and MissCount, output, 32 each, the statistics counters.

Function
REQ-015 Entry organisation SHALL be direct-mapped: index = PC[ENTRY_BITS+1:2], tag = PC[31:ENTRY_BITS+2], with a 32-bit target and a valid bit per entry.
REQ-016 Lookup SHALL be combinational with zero latency: hit = valid[idx] AND tag match.
REQ-017 MispredictE SHALL be: en AND ((BranchE AND BRPredictedE != BrTakenE) OR (NOT BranchE AND BRPredictedE)).
REQ-018 RecoverPCE SHALL equal BrTargetE when BranchE AND BrTakenE, and PCE+4 otherwise, with 32-bit wrap.
REQ-019 Allocation SHALL occur when en AND BranchE AND BrTakenE and the PCE entry misses: write tag, target and valid=1, overwriting any aliased entry.
REQ-020 Invalidation SHALL occur when en AND BRPredictedE AND NOT BranchE: clear valid at the PCE index.
REQ-021 When a lookup and an update hit the same index in one cycle, the lookup SHALL return pre-update contents; the new value is visible next cycle.
REQ-022 BrCount SHALL increment on en AND BranchE; MissCount SHALL increment on MispredictE; both SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-023 Assertion of rst_n=0 SHALL immediately clear all valid bits, counters, BrCount and MissCount.
REQ-024 Under reset, BRPredictedF SHALL be 0 and PredTargetF SHALL be 0.
REQ-025 Reset asserted mid-update SHALL win; no partial entry write SHALL survive it.

Configuration
REQ-026 Macro BTB_BHT_EN SHALL select between two prediction modes as follows.
- Defined: each entry SHALL hold a 2-bit saturating counter. Allocation SHALL set it to 2'b10. On an en AND BranchE hit, taken SHALL increment it (saturating at 3) and not-taken SHALL decrement it (saturating at 0). Entries SHALL stay valid. The prediction SHALL be hit AND counter[1].
- Undefined: there SHALL be no counters, and the prediction SHALL be hit. On en AND BranchE AND NOT BrTakenE with a hit, the entry SHALL be invalidated.

Verification
REQ-027 Cold branch: PCE=0x100, taken to 0x80, BRPredictedE=0 -> MispredictE=1, RecoverPCE=0x80, entry 0 written; next cycle PCF=0x100 -> BRPredictedF=1, PredTargetF=0x80.
REQ-028 Not-taken on predicted entry, PCE=0x100 -> MispredictE=1, RecoverPCE=0x104. Without BTB_BHT_EN, the following lookup of 0x100 -> 0. With BTB_BHT_EN (counter 10 to 01), the following lookup -> 0 as well.
REQ-029 Alias: allocate 0x100, then allocate 0x140 (same index, different tag) -> lookup 0x100 -> BRPredictedF=0; lookup 0x140 -> 1.
REQ-030 Same-index lookup and update in one cycle -> lookup returns the old entry; the new entry is seen the next cycle.
REQ-031 en=0 with BranchE=1 and BrTakenE=1 -> no table change, MispredictE=0, counters unchanged.
REQ-032 Pulse rst_n low mid-run after BrCount=5 -> BrCount=0, MissCount=0, all lookups return 0 without waiting for a clock edge.
